// File: rtl/llc_mem_responder_if.sv
// Line-request, line-response and word-bus signals of the LLC memory responder.
// slave = responder side, master = LLC core / SoC memory side.
interface llc_mem_responder_if #(
  parameter int unsigned WORD_BITS      = 64,
  parameter int unsigned WORDS_PER_LINE = 2,
  parameter int unsigned ADDR_BITS      = 32
);
  localparam int unsigned LINE_BITS      = WORD_BITS * WORDS_PER_LINE;
  localparam int unsigned OFF_BITS       = $clog2(WORD_BITS / 8) + $clog2(WORDS_PER_LINE);
  localparam int unsigned LINE_ADDR_BITS = ADDR_BITS - OFF_BITS;

  logic                      mem_req_valid;
  logic                      mem_req_ready;
  logic                      mem_req_hwrite;
  logic [LINE_ADDR_BITS-1:0] mem_req_addr;
  logic [LINE_BITS-1:0]      mem_req_line;
  logic                      mem_rsp_valid;
  logic                      mem_rsp_ready;
  logic [LINE_BITS-1:0]      mem_rsp_line;
  logic                      bus_valid;
  logic                      bus_ready;
  logic                      bus_write;
  logic [ADDR_BITS-1:0]      bus_addr;
  logic [WORD_BITS-1:0]      bus_wdata;
  logic                      bus_rvalid;
  logic [WORD_BITS-1:0]      bus_rdata;

  modport slave (
    input  mem_req_valid, mem_req_hwrite, mem_req_addr, mem_req_line,
    input  mem_rsp_ready, bus_ready, bus_rvalid, bus_rdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_line,
    output bus_valid, bus_write, bus_addr, bus_wdata
  );

  modport master (
    output mem_req_valid, mem_req_hwrite, mem_req_addr, mem_req_line,
    output mem_rsp_ready, bus_ready, bus_rvalid, bus_rdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_line,
    input  bus_valid, bus_write, bus_addr, bus_wdata
  );
endinterface

// File: rtl/llc_mem_responder.sv
// Splits LLC line requests into word beats on the memory bus and assembles read lines.
// Define LLC_MEM_WR_ACK_EN to acknowledge each write with an all-zero response line.
module llc_mem_responder #(
  parameter int unsigned WORD_BITS      = 64,
  parameter int unsigned WORDS_PER_LINE = 2,
  parameter int unsigned ADDR_BITS      = 32
) (
  input logic               clk,
  input logic               rst,
  llc_mem_responder_if.slave mif
);
  localparam int unsigned LINE_BITS      = WORD_BITS * WORDS_PER_LINE;
  localparam int unsigned WORD_OFF_BITS  = $clog2(WORD_BITS / 8);
  localparam int unsigned IDX_BITS       = $clog2(WORDS_PER_LINE);
  localparam int unsigned OFF_BITS       = WORD_OFF_BITS + IDX_BITS;
  localparam int unsigned LINE_ADDR_BITS = ADDR_BITS - OFF_BITS;

  typedef enum logic [2:0] {StIdle, StWrBeat, StRdAddr, StRdData, StRespond} state_e;

  state_e                    state_q, state_d;
  logic [LINE_ADDR_BITS-1:0] addr_q, addr_d;
  logic [LINE_BITS-1:0]      line_q, line_d;
  logic [LINE_BITS-1:0]      rsp_q, rsp_d;
  logic [IDX_BITS-1:0]       idx_q, idx_d;
  logic                      last;

  assign last = (idx_q == IDX_BITS'(WORDS_PER_LINE - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      line_q  <= '0;
      rsp_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      rsp_q   <= rsp_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    line_d  = line_q;
    rsp_d   = rsp_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (mif.mem_req_valid) begin
          addr_d  = mif.mem_req_addr;
          line_d  = mif.mem_req_line;
          // Cleared here so a write ack carries an all-zero line.
          rsp_d   = '0;
          idx_d   = '0;
          state_d = mif.mem_req_hwrite ? StWrBeat : StRdAddr;
        end
      end
      StWrBeat: begin
        if (mif.bus_ready) begin
          if (last) begin
`ifdef LLC_MEM_WR_ACK_EN
            state_d = StRespond;
`else
            state_d = StIdle;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StRdAddr: begin
        if (mif.bus_ready) begin
          state_d = StRdData;
        end
      end
      StRdData: begin
        if (mif.bus_rvalid) begin
          rsp_d[idx_q*WORD_BITS +: WORD_BITS] = mif.bus_rdata;
          if (last) begin
            state_d = StRespond;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StRdAddr;
          end
        end
      end
      StRespond: begin
        if (mif.mem_rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign mif.mem_req_ready = (state_q == StIdle);
  assign mif.mem_rsp_valid = (state_q == StRespond);
  assign mif.mem_rsp_line  = rsp_q;
  assign mif.bus_valid     = (state_q == StWrBeat) || (state_q == StRdAddr);
  assign mif.bus_write     = (state_q == StWrBeat);
  assign mif.bus_addr      = {addr_q, idx_q, {WORD_OFF_BITS{1'b0}}};
  assign mif.bus_wdata     = line_q[idx_q*WORD_BITS +: WORD_BITS];

endmodule

// File: tb/tb_llc_mem_responder.sv
// Directed bench for llc_mem_responder at default parameters (64-bit words, 2 words per line).
module tb_llc_mem_responder;
  localparam int unsigned WORD_BITS      = 64;
  localparam int unsigned WORDS_PER_LINE = 2;
  localparam int unsigned ADDR_BITS      = 32;

  localparam logic [63:0] W1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] W2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] W3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] W4 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] WD = 64'hDEAD_BEEF_DEAD_BEEF;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  llc_mem_responder_if #(
    .WORD_BITS      (WORD_BITS),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .ADDR_BITS      (ADDR_BITS)
  ) mif ();

  llc_mem_responder #(
    .WORD_BITS      (WORD_BITS),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .ADDR_BITS      (ADDR_BITS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mif (mif)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read with bus_ready high and each word returned the cycle after its address beat.
  task automatic run_read(input logic [27:0] a, input logic [63:0] d0, input logic [63:0] d1,
                          input logic [31:0] ea0, input logic [31:0] ea1);
    mif.mem_req_valid  = 1'b1;
    mif.mem_req_hwrite = 1'b0;
    mif.mem_req_addr   = a;
    mif.bus_ready      = 1'b1;
    tick();
    mif.mem_req_valid = 1'b0;
    check("rd_c1_valid", 128'(mif.bus_valid), 128'd1);
    check("rd_c1_write", 128'(mif.bus_write), 128'd0);
    check("rd_c1_addr", 128'(mif.bus_addr), 128'(ea0));
    check("rd_c1_reqrdy", 128'(mif.mem_req_ready), 128'd0);
    tick();
    check("rd_c2_valid", 128'(mif.bus_valid), 128'd0);
    mif.bus_rvalid = 1'b1;
    mif.bus_rdata  = d0;
    tick();
    mif.bus_rvalid = 1'b0;
    mif.bus_rdata  = '0;
    check("rd_c3_valid", 128'(mif.bus_valid), 128'd1);
    check("rd_c3_addr", 128'(mif.bus_addr), 128'(ea1));
    tick();
    mif.bus_rvalid = 1'b1;
    mif.bus_rdata  = d1;
    check("rd_c4_rspvalid", 128'(mif.mem_rsp_valid), 128'd0);
    tick();
    mif.bus_rvalid = 1'b0;
    mif.bus_rdata  = '0;
    check("rd_c5_rspvalid", 128'(mif.mem_rsp_valid), 128'd1);
    check("rd_c5_line", 128'(mif.mem_rsp_line), {d1, d0});
  endtask

  initial begin
    rst                = 1'b0;
    mif.mem_req_valid  = 1'b1;
    mif.mem_req_hwrite = 1'b0;
    mif.mem_req_addr   = 28'h10;
    mif.mem_req_line   = '0;
    mif.mem_rsp_ready  = 1'b0;
    mif.bus_ready      = 1'b1;
    mif.bus_rvalid     = 1'b0;
    mif.bus_rdata      = '0;

    // Reset held with a request pending: nothing may leave the block.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_reqrdy", 128'(mif.mem_req_ready), 128'd1);
      check("rst_busvalid", 128'(mif.bus_valid), 128'd0);
      check("rst_rspvalid", 128'(mif.mem_rsp_valid), 128'd0);
    end
    check("rst_buswrite", 128'(mif.bus_write), 128'd0);
    check("rst_busaddr", 128'(mif.bus_addr), 128'd0);
    check("rst_wdata", 128'(mif.bus_wdata), 128'd0);
    check("rst_rspline", 128'(mif.mem_rsp_line), 128'd0);
    mif.mem_req_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("post_rst_reqrdy", 128'(mif.mem_req_ready), 128'd1);

    run_read(28'h10, W1, W2, 32'h100, 32'h108);

    // Response backpressure with a write request waiting.
    mif.mem_req_valid  = 1'b1;
    mif.mem_req_hwrite = 1'b1;
    mif.mem_req_addr   = 28'h3;
    mif.mem_req_line   = {64'hB, 64'hA};
    mif.bus_ready      = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("bp_rspvalid", 128'(mif.mem_rsp_valid), 128'd1);
      check("bp_line", 128'(mif.mem_rsp_line), {W2, W1});
      check("bp_reqrdy", 128'(mif.mem_req_ready), 128'd0);
      tick();
    end
    mif.mem_rsp_ready = 1'b1;
    tick();
    mif.mem_rsp_ready = 1'b0;
    check("hs_reqrdy", 128'(mif.mem_req_ready), 128'd1);
    check("hs_rspvalid", 128'(mif.mem_rsp_valid), 128'd0);
    check("hs_busvalid", 128'(mif.bus_valid), 128'd0);
    tick();
    mif.mem_req_valid = 1'b0;

    // Write beats, each stalled for three cycles.
    for (int i = 0; i < 3; i++) begin
      check("wr0_valid", 128'(mif.bus_valid), 128'd1);
      check("wr0_write", 128'(mif.bus_write), 128'd1);
      check("wr0_addr", 128'(mif.bus_addr), 128'h30);
      check("wr0_wdata", 128'(mif.bus_wdata), 128'hA);
      tick();
    end
    mif.bus_ready = 1'b1;
    check("wr0_addr_acc", 128'(mif.bus_addr), 128'h30);
    tick();
    mif.bus_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("wr1_valid", 128'(mif.bus_valid), 128'd1);
      check("wr1_write", 128'(mif.bus_write), 128'd1);
      check("wr1_addr", 128'(mif.bus_addr), 128'h38);
      check("wr1_wdata", 128'(mif.bus_wdata), 128'hB);
      check("wr1_rspvalid", 128'(mif.mem_rsp_valid), 128'd0);
      tick();
    end
    mif.bus_ready = 1'b1;
    tick();
    mif.bus_ready = 1'b0;
`ifdef LLC_MEM_WR_ACK_EN
    for (int i = 0; i < 3; i++) begin
      check("ack_rspvalid", 128'(mif.mem_rsp_valid), 128'd1);
      check("ack_line", 128'(mif.mem_rsp_line), 128'd0);
      check("ack_reqrdy", 128'(mif.mem_req_ready), 128'd0);
      check("ack_busvalid", 128'(mif.bus_valid), 128'd0);
      tick();
    end
    mif.mem_rsp_ready = 1'b1;
    tick();
    mif.mem_rsp_ready = 1'b0;
    check("ack_done_rspvalid", 128'(mif.mem_rsp_valid), 128'd0);
    check("ack_done_reqrdy", 128'(mif.mem_req_ready), 128'd1);
    tick();
    check("ack_once", 128'(mif.mem_rsp_valid), 128'd0);
`else
    check("wr_done_reqrdy", 128'(mif.mem_req_ready), 128'd1);
    check("wr_done_rspvalid", 128'(mif.mem_rsp_valid), 128'd0);
    check("wr_done_busvalid", 128'(mif.bus_valid), 128'd0);
    tick();
    check("wr_silent", 128'(mif.mem_rsp_valid), 128'd0);
`endif

    // Reset pulsed after the first word of a read has been stored.
    mif.mem_req_valid  = 1'b1;
    mif.mem_req_hwrite = 1'b0;
    mif.mem_req_addr   = 28'h20;
    mif.bus_ready      = 1'b1;
    tick();
    mif.mem_req_valid = 1'b0;
    tick();
    mif.bus_rvalid = 1'b1;
    mif.bus_rdata  = WD;
    tick();
    mif.bus_rvalid = 1'b0;
    check("mid_addr1", 128'(mif.bus_addr), 128'h208);
    rst = 1'b0;
    #1;
    check("mid_rst_reqrdy", 128'(mif.mem_req_ready), 128'd1);
    check("mid_rst_busvalid", 128'(mif.bus_valid), 128'd0);
    check("mid_rst_rspline", 128'(mif.mem_rsp_line), 128'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_no_rsp", 128'(mif.mem_rsp_valid), 128'd0);
      check("mid_idle_bus", 128'(mif.bus_valid), 128'd0);
    end
    run_read(28'h20, W3, W4, 32'h200, 32'h208);
    mif.mem_rsp_ready = 1'b1;
    tick();
    mif.mem_rsp_ready = 1'b0;
    check("end_rspvalid", 128'(mif.mem_rsp_valid), 128'd0);
    check("end_reqrdy", 128'(mif.mem_req_ready), 128'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
